ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side master for the RAM512 memory block.
- Walks a contiguous address range in RAM512 and streams each 16-bit word out over a valid/ready handshake.
- Sits between RAM512 and any downstream consumer: display scanner, checksum unit, or serial transmitter.
- Never writes: it drives RAM512's load low at all times and only issues reads.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 16, word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request a burst; sampled only in IDLE.
- base  input  ADDR_W  first address of the burst; captured with start.
- count  input  ADDR_W+1  number of words, 0..512; captured with start.
- mem_load  output  1  to RAM512 load; constant 0.
- mem_address  output  ADDR_W  to RAM512 address; registered.
- mem_in  output  DATA_W  to RAM512 in; constant 0.
- mem_out  input  DATA_W  from RAM512 out; combinational read of mem_address.
- data  output  DATA_W  streamed word; registered.
- valid  output  1  data holds a word not yet accepted.
- ready  input  1  consumer accepts data when valid && ready at a rising edge.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted, or for an empty burst.

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-burst):
  - state=IDLE; mem_address=0; data=0; valid=0; done=0; busy=0; remaining=0.
  - Burst in flight is abandoned; nothing resumes after reset releases.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - done defaults to 0 every cycle except where it is explicitly pulsed.
  - start=1 and count!=0: mem_address<=base; remaining<=count; go to FETCH.
  - start=1 and count==0: done<=1 for one cycle; stay in IDLE; mem_address unchanged.
- FETCH:
  - mem_address was stable during the previous cycle, so mem_out is valid.
  - data<=mem_out; valid<=1; go to HOLD.
- HOLD:
  - valid stays 1 and data stays stable until valid && ready.
  - On accept: valid<=0; remaining<=remaining-1.
  - If remaining==1: done<=1; go to IDLE; mem_address holds last burst address.
  - Else: mem_address<=mem_address+1 (modulo 2^ADDR_W, so 511 wraps to 0); go to FETCH.
- Latency and throughput:
  - start accepted at edge N: first valid at edge N+2.
  - With ready held high: one word per 2 cycles.
  - done asserted at edge N+2*count+1.
- Handshake rules:
  - ready is ignored while valid=0.
  - valid never drops without an accept, except on reset.
  - data never changes while valid=1.
- start while busy=1 is ignored; no queuing. start coincident with the done pulse is ignored; start is sampled only in IDLE.
- count of 512 reads the entire RAM, wrapping from base back to base-1.
- busy is combinational from state.

Optional Feature:
- Macro: RAM_BURST_READER_CHECKSUM_EN.
- With the macro defined:
  - Adds output port checksum (DATA_W).
  - Cleared to 0 when a burst starts, including count==0.
  - On every accept, checksum<=checksum+data, mod 2^DATA_W.
  - Final value is stable from the done pulse until the next start.
  - Reset value 0.
- Without the macro: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Basic burst:
  - Stimulus: preload RAM[i]=0x0100+i for i=0..19; start, base=0, count=4, ready=1.
  - Response: data sequence 0x0100, 0x0101, 0x0102, 0x0103; valid first seen 2 edges after start; done pulses exactly once, 9 edges after start.
  - mem_load is 0 throughout.
- Backpressure:
  - Stimulus: base=5, count=2; ready=0 for 6 cycles after first valid, then 1.
  - Response: data held at 0x0105 with valid=1 for all stall cycles; then 0x0106; mem_address does not advance during the stall.
- Wrap-around:
  - Stimulus: RAM[510]=0xAAAA, RAM[511]=0xBBBB, RAM[0]=0xCCCC; base=510, count=3.
  - Response: outputs 0xAAAA, 0xBBBB, 0xCCCC; mem_address sequence 510, 511, 0.
- Empty burst and start-while-busy:
  - Stimulus: count=0.
  - Response: done pulses next edge, busy never rises, valid never rises.
  - Stimulus: during a count=3 burst, pulse start with base=100.
  - Response: the pulse is ignored; exactly 3 words come from the original base.
- Reset mid-burst:
  - Stimulus: drop rst_n for one edge during HOLD of word 2 of 5.
  - Response: valid=0, busy=0, data=0, mem_address=0, no done pulse.
  - Follow-up: a new start with base=0, count=1 returns 0x0100 normally.
- Checksum (with RAM_BURST_READER_CHECKSUM_EN):
  - Stimulus: basic burst above.
  - Response: checksum=0x0406 at the done pulse.
  - Stimulus: RAM[0..1]=0xFFFF, count=2.
  - Response: checksum=0xFFFE.

Source files
------------

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-only burst master for RAM512.
// Walks base..base+count-1 (addresses wrap modulo 2^ADDR_W) and streams each
// word out over a valid/ready handshake. done pulses for one cycle after the
// last accept, or straight away for an empty burst.
// Optional build macro: RAM_BURST_READER_CHECKSUM_EN adds a running 16-bit
// checksum of the accepted words on output port checksum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; done may pulse here
// S_FETCH | mem_address settled last cycle, capture mem_out into data
// S_HOLD  | data/valid presented, wait for ready, then advance or finish
module ram_burst_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
`ifdef RAM_BURST_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_address;
    logic [ADDR_W:0]     r_remaining;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_done;

    logic                w_start_ok;
    logic                w_load_burst;
    logic                w_capture;
    logic                w_accept;
    logic                w_advance;
    logic                w_done_nxt;
    logic                w_last;

    // A start landing on the done-pulse cycle is dropped so the consumer
    // always sees at least one idle cycle with done high before a new burst.
    assign w_start_ok = (r_state == S_IDLE) && start && !r_done;
    assign w_accept   = (r_state == S_HOLD) && r_valid && ready;
    assign w_last     = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_burst = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    if (count != '0) begin
                        w_load_burst = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_capture   = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address, word counter, output word and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_address   <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_load_burst) begin
                r_address   <= base;
                r_remaining <= count;
            end
            if (w_capture) begin
                r_data  <= mem_out;
                r_valid <= 1'b1;
            end
            if (w_accept) begin
                r_valid     <= 1'b0;
                r_remaining <= r_remaining - {{ADDR_W{1'b0}}, 1'b1};
            end
            if (w_advance) begin
                r_address <= r_address + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of accepted words, cleared on every accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign mem_load    = 1'b0;
    assign mem_in      = '0;
    assign mem_address = r_address;
    assign data        = r_data;
    assign valid       = r_valid;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural RAM512 model.
module tb_ram_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_i;
    logic [9:0]  count_i;
    logic        mem_load;
    logic [8:0]  mem_address;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
`ifdef RAM_BURST_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [15:0] ram [0:511];

    int tests;
    int fails;

    ram_burst_reader #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base        (base_i),
        .count       (count_i),
        .mem_load    (mem_load),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy),
`ifdef RAM_BURST_READER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .done        (done)
    );

    assign mem_out = ram[mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  setup;     // 0 ramp, 1 wrap pattern, 2 0xFFFF pair
        logic [8:0]  base;
        logic [9:0]  cnt;
        int          stall;
        int          mid_j;     // negedge index for a stray start, -1 none
        logic [15:0] e_first;
        logic [15:0] e_last;
        logic [15:0] e_sum;
        logic [8:0]  e_alast;
        int          e_done;    // edges from start to visible done
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [vec %0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic setup_ram(input logic [1:0] kind);
        for (int i = 0; i < 512; i++) ram[i] = 16'h0100 + 16'(i);
        if (kind == 2'd1) begin
            ram[510] = 16'hAAAA;
            ram[511] = 16'hBBBB;
            ram[0]   = 16'hCCCC;
        end else if (kind == 2'd2) begin
            ram[0] = 16'hFFFF;
            ram[1] = 16'hFFFF;
        end
    endtask

    task automatic run_burst(input int idx, input vec_t v);
        int          first_j;
        int          done_j;
        int          ndone;
        int          nwords;
        int          stall_left;
        int          stall_seen;
        logic        busy_seen;
        logic        bad_ctl;
        logic [15:0] w0;
        logic [15:0] wl;
        logic [8:0]  al;
        logic [8:0]  ea;
        logic [15:0] sum_at_done;
        first_j = -1; done_j = -1; ndone = 0; nwords = 0;
        stall_left = v.stall; stall_seen = 0;
        busy_seen = 1'b0; bad_ctl = 1'b0;
        w0 = '0; wl = '0; al = '0; sum_at_done = '0;
        @(negedge clk);
        base_i  = v.base;
        count_i = v.cnt;
        start   = 1'b1;
        ready   = (v.stall == 0);
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 1; j <= 1200; j++) begin
            @(negedge clk);
            if (j == v.mid_j) begin
                start  = 1'b1;
                base_i = 9'd100;
            end else if (j == v.mid_j + 1) begin
                start = 1'b0;
            end
            if (mem_load !== 1'b0 || mem_in !== 16'h0) bad_ctl = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                ndone++;
                if (done_j < 0) begin
                    done_j = j;
`ifdef RAM_BURST_READER_CHECKSUM_EN
                    sum_at_done = checksum;
`endif
                end
            end
            if (valid && first_j < 0) first_j = j;
            if (valid) begin
                if (stall_left > 0) begin
                    check("stall_data", idx, 32'(data), 32'(v.e_first));
                    check("stall_addr", idx, 32'(mem_address), 32'(v.base));
                    stall_left--;
                    stall_seen++;
                    ready = 1'b0;
                end else begin
                    ready = 1'b1;
                end
                if (ready) begin
                    ea = v.base + 9'(nwords);
                    check("word_data", idx, 32'(data), 32'(ram[ea]));
                    check("word_addr", idx, 32'(mem_address), 32'(ea));
                    if (nwords == 0) w0 = data;
                    wl = data;
                    al = mem_address;
                    nwords++;
                end
            end
            if (done_j >= 0 && j >= done_j + 3) break;
        end
        check("nwords", idx, 32'(nwords), 32'(v.cnt));
        check("done_edge", idx, 32'(done_j), 32'(v.e_done));
        check("done_once", idx, 32'(ndone), 32'd1);
        check("ctl_const", idx, 32'(bad_ctl), 32'd0);
        check("stall_cycles", idx, 32'(stall_seen), 32'(v.stall));
        if (v.cnt != 10'd0) begin
            check("first_valid", idx, 32'(first_j), 32'd2);
            check("first_word", idx, 32'(w0), 32'(v.e_first));
            check("last_word", idx, 32'(wl), 32'(v.e_last));
            check("last_addr", idx, 32'(al), 32'(v.e_alast));
        end else begin
            check("empty_busy", idx, 32'(busy_seen), 32'd0);
            check("empty_valid", idx, 32'(first_j), 32'hFFFF_FFFF);
        end
`ifdef RAM_BURST_READER_CHECKSUM_EN
        check("checksum_done", idx, 32'(sum_at_done), 32'(v.e_sum));
        check("checksum_hold", idx, 32'(checksum), 32'(v.e_sum));
`endif
    endtask

    initial begin
        vec_t v;
        int   nw;
        logic found;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; base_i = '0; count_i = '0; ready = 1'b0;
        setup_ram(2'd0);

        vecs[0] = '{2'd0, 9'd0,   10'd4,   0, -1, 16'h0100, 16'h0103, 16'h0406, 9'd3,   9};
        vecs[1] = '{2'd0, 9'd5,   10'd2,   6, -1, 16'h0105, 16'h0106, 16'h020B, 9'd6,   11};
        vecs[2] = '{2'd0, 9'd10,  10'd1,   0, -1, 16'h010A, 16'h010A, 16'h010A, 9'd10,  3};
        vecs[3] = '{2'd0, 9'd7,   10'd0,   0, -1, 16'h0000, 16'h0000, 16'h0000, 9'd0,   1};
        vecs[4] = '{2'd0, 9'd17,  10'd3,   0,  3, 16'h0111, 16'h0113, 16'h0336, 9'd19,  7};
        vecs[5] = '{2'd1, 9'd510, 10'd3,   0, -1, 16'hAAAA, 16'hCCCC, 16'h3331, 9'd0,   7};
        vecs[6] = '{2'd2, 9'd0,   10'd2,   0, -1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 9'd1,   5};
        vecs[7] = '{2'd0, 9'd3,   10'd512, 0, -1, 16'h0103, 16'h0102, 16'hFF00, 9'd2,   1025};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", -1, 32'(valid), 32'd0);
        check("rst_busy", -1, 32'(busy), 32'd0);
        check("rst_done", -1, 32'(done), 32'd0);
        check("rst_data", -1, 32'(data), 32'd0);
        check("rst_addr", -1, 32'(mem_address), 32'd0);
        check("rst_load", -1, 32'(mem_load), 32'd0);
`ifdef RAM_BURST_READER_CHECKSUM_EN
        check("rst_checksum", -1, 32'(checksum), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            setup_ram(vecs[k].setup);
            run_burst(k, vecs[k]);
        end

        // Reset during HOLD of word 2 of a 5-word burst.
        setup_ram(2'd0);
        @(negedge clk);
        base_i = 9'd0; count_i = 10'd5; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nw = 0; found = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (valid) begin
                if (nw == 1) begin
                    found = 1'b1;
                    break;
                end
                nw++;
            end
        end
        check("rst_reached_word2", 20, 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_valid", 20, 32'(valid), 32'd0);
        check("mid_rst_busy", 20, 32'(busy), 32'd0);
        check("mid_rst_data", 20, 32'(data), 32'd0);
        check("mid_rst_addr", 20, 32'(mem_address), 32'd0);
        check("mid_rst_done", 20, 32'(done), 32'd0);
        found = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done || valid || busy) found = 1'b1;
        end
        check("mid_rst_quiet", 20, 32'(found), 32'd0);
        v = '{2'd0, 9'd0, 10'd1, 0, -1, 16'h0100, 16'h0100, 16'h0100, 9'd0, 3};
        run_burst(21, v);

        // start held through the done pulse: that cycle's start is dropped.
        @(negedge clk);
        base_i = 9'd0; count_i = 10'd1; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 3) check("hold_start_done", 22, 32'(done), 32'd1);
            if (j == 4) check("hold_start_ignored", 22, 32'(busy), 32'd0);
            if (j == 5) check("hold_start_next", 22, 32'(busy), 32'd1);
        end
        start = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("hold_start_done2", 22, 32'(found), 32'd1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
